// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_PIPE = 1'b0,
    S_DMA  = 1'b1
  } state_t;

  localparam int unsigned MAX_WAIT_DEF  = 8;
  localparam int unsigned BURST_MAX_DEF = 4;
  localparam int unsigned AW_DEF        = 32;
  localparam int unsigned DW_DEF        = 32;
  // Starvation counters only need to reach 255.
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module dmem_arb_starve_ctr #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up to MAX and hold there until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: memory-stage port has fixed priority, DMA port gets a
// forced grant after MAX_WAIT denied cycles and may then hold the memory for
// up to BURST_MAX beats while the pipeline is waiting.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_req,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wd,
  output logic [DW-1:0] pipe_rd,
  output logic          stall_o,
  input  logic          dma_valid,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wd,
  output logic          dma_ready,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   dma_beats
`endif
);

  state_t             state;
  state_t             state_nxt;
  logic               grant_dma;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   beat_cnt;

  // Denied DMA cycles; restarts whenever the DMA is served or goes idle.
  dmem_arb_starve_ctr #(.W(CNT_W), .MAX(MAX_WAIT)) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_dma || !dma_valid),
    .inc   (dma_valid && !grant_dma),
    .cnt   (wait_cnt)
  );

  // Beats taken from a waiting pipeline; zero whenever the DMA is not granted,
  // so the first beat of a burst always loads 1 (or stays 0 if pipeline idle).
  dmem_arb_starve_ctr #(.W(CNT_W), .MAX(BURST_MAX)) u_beat_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!grant_dma),
    .inc   (grant_dma && pipe_req),
    .cnt   (beat_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PIPE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: DMA owns the memory exactly while it keeps being granted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_PIPE: if (grant_dma)  state_nxt = S_DMA;
      S_DMA:  if (!grant_dma) state_nxt = S_PIPE;
    endcase
  end

  // Grant decision and memory mux; everything forced quiet while in reset.
  always_comb begin
    grant_dma = 1'b0;
    if (rst_n) begin
      case (state)
        S_PIPE: grant_dma = dma_valid && (!pipe_req || (wait_cnt == CNT_W'(MAX_WAIT)));
        S_DMA:  grant_dma = dma_valid && (!pipe_req || (beat_cnt < CNT_W'(BURST_MAX)));
      endcase
    end
    dma_ready = grant_dma;
    stall_o   = grant_dma && pipe_req;
    pipe_rd   = mem_rd;
    if (grant_dma) begin
      mem_we = dma_we;
      mem_a  = dma_addr;
      mem_wd = dma_wd;
    end else begin
      mem_we = rst_n && pipe_req && pipe_we;
      mem_a  = pipe_addr;
      mem_wd = pipe_wd;
    end
  end

  // DMA read return, one cycle after the granted read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= grant_dma && !dma_we;
      if (grant_dma && !dma_we) begin
        dma_rdata <= mem_rd;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Free-running stall and DMA-beat counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      dma_beats <= '0;
    end else begin
      if (stall_o)   stall_cnt <= stall_cnt + 32'd1;
      if (grant_dma) dma_beats <= dma_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port data memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_req, pipe_we;
  logic [31:0] pipe_addr, pipe_wd, pipe_rd;
  logic        stall_o;
  logic        dma_valid, dma_we;
  logic [31:0] dma_addr, dma_wd;
  logic        dma_ready, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt, dma_beats;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] mem_arr [0:255];

  always #5 clk = ~clk;

  assign mem_rd = mem_arr[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_a[9:2]] <= mem_wd;
  end

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wd    (pipe_wd),
    .pipe_rd    (pipe_rd),
    .stall_o    (stall_o),
    .dma_valid  (dma_valid),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wd     (dma_wd),
    .dma_ready  (dma_ready),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
`ifdef DMEM_ARB_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .dma_beats  (dma_beats)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = 32'h0; pipe_wd = 32'h0;
    dma_valid = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wd = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", dma_rvalid); else pass_cnt++;
    chk_cnt++; if (dma_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", dma_rdata); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else pass_cnt++;
    chk_cnt++; if (dut.state !== S_PIPE) $display("FAIL reset_state: got %0d expected S_PIPE", dut.state); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_store_load();
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h10; pipe_wd = 32'hDEADBEEF;
    #1;
    chk_cnt++; if (mem_we !== 1'b1) $display("FAIL pipe_st_we: got %b expected 1", mem_we); else pass_cnt++;
    chk_cnt++; if (mem_a !== 32'h10) $display("FAIL pipe_st_addr: got %h expected 10", mem_a); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL pipe_st_stall: got %b expected 0", stall_o); else pass_cnt++;
    tick();
    pipe_we = 1'b0; pipe_wd = 32'h0;
    #1;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL pipe_ld_we: got %b expected 0", mem_we); else pass_cnt++;
    chk_cnt++; if (pipe_rd !== 32'hDEADBEEF) $display("FAIL pipe_ld_rd: got %h expected deadbeef", pipe_rd); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL pipe_ld_stall: got %b expected 0", stall_o); else pass_cnt++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_dma_rw();
    dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wd = 32'h12345678;
    #1;
    chk_cnt++; if (dma_ready !== 1'b1) $display("FAIL dma_wr_ready: got %b expected 1", dma_ready); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b1) $display("FAIL dma_wr_we: got %b expected 1", mem_we); else pass_cnt++;
    chk_cnt++; if (mem_a !== 32'h20) $display("FAIL dma_wr_addr: got %h expected 20", mem_a); else pass_cnt++;
    tick();
    chk_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL dma_wr_rvalid: got %b expected 0", dma_rvalid); else pass_cnt++;
    dma_we = 1'b0; dma_wd = 32'h0;
    #1;
    chk_cnt++; if (dma_ready !== 1'b1) $display("FAIL dma_rd_ready: got %b expected 1", dma_ready); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL dma_rd_we: got %b expected 0", mem_we); else pass_cnt++;
    tick();
    dma_valid = 1'b0;
    chk_cnt++; if (dma_rvalid !== 1'b1) $display("FAIL dma_rd_rvalid: got %b expected 1", dma_rvalid); else pass_cnt++;
    chk_cnt++; if (dma_rdata !== 32'h12345678) $display("FAIL dma_rd_data: got %h expected 12345678", dma_rdata); else pass_cnt++;
    tick();
    chk_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL dma_rvalid_drop: got %b expected 0", dma_rvalid); else pass_cnt++;
    chk_cnt++; if (dma_rdata !== 32'h12345678) $display("FAIL dma_rdata_hold: got %h expected 12345678", dma_rdata); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic        exp_g;
    logic [31:0] exp_a;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] st0, bt0;
    st0 = stall_cnt; bt0 = dma_beats;
`endif
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 32'h40;
    dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wd = 32'hA5A5A5A5;
    for (int c = 0; c < 24; c++) begin
      #1;
      exp_g = ((c % 12) >= 8);
      exp_a = exp_g ? 32'h80 : 32'h40;
      chk_cnt++; if (stall_o !== exp_g) $display("FAIL cont_stall c=%0d: got %b expected %b", c, stall_o, exp_g); else pass_cnt++;
      chk_cnt++; if (dma_ready !== exp_g) $display("FAIL cont_ready c=%0d: got %b expected %b", c, dma_ready, exp_g); else pass_cnt++;
      chk_cnt++; if (mem_a !== exp_a) $display("FAIL cont_addr c=%0d: got %h expected %h", c, mem_a, exp_a); else pass_cnt++;
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    chk_cnt++; if ((stall_cnt - st0) !== 32'd8) $display("FAIL perf_stall: got %0d expected 8", stall_cnt - st0); else pass_cnt++;
    chk_cnt++; if ((dma_beats - bt0) !== 32'd8) $display("FAIL perf_beats: got %0d expected 8", dma_beats - bt0); else pass_cnt++;
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_burst();
    dma_valid = 1'b1; dma_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dma_addr = 32'h100 + 32'(4 * i); dma_wd = 32'(i);
      #1;
      chk_cnt++; if (dma_ready !== 1'b1) $display("FAIL idle_ready i=%0d: got %b expected 1", i, dma_ready); else pass_cnt++;
      chk_cnt++; if (stall_o !== 1'b0) $display("FAIL idle_stall i=%0d: got %b expected 0", i, stall_o); else pass_cnt++;
      tick();
      chk_cnt++; if (dut.beat_cnt !== 8'd0) $display("FAIL idle_beat_cnt i=%0d: got %0d expected 0", i, dut.beat_cnt); else pass_cnt++;
    end
    // Pipeline arrives mid-burst: the full burst allowance is still available.
    pipe_req = 1'b1; pipe_addr = 32'h40;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++; if (stall_o !== (c < 4)) $display("FAIL burst_stall c=%0d: got %b expected %b", c, stall_o, (c < 4)); else pass_cnt++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    tick();
    chk_cnt++; if (dma_rvalid !== 1'b1) $display("FAIL rmb_rvalid_pre: got %b expected 1", dma_rvalid); else pass_cnt++;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h30; pipe_wd = 32'hCAFEF00D;
    #1;
    chk_cnt++; if (stall_o !== 1'b1) $display("FAIL rmb_stall_pre: got %b expected 1", stall_o); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL rmb_stall: got %b expected 0", stall_o); else pass_cnt++;
    chk_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL rmb_rvalid: got %b expected 0", dma_rvalid); else pass_cnt++;
    chk_cnt++; if (dma_ready !== 1'b0) $display("FAIL rmb_ready: got %b expected 0", dma_ready); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL rmb_mem_we: got %b expected 0", mem_we); else pass_cnt++;
    chk_cnt++; if (dut.state !== S_PIPE) $display("FAIL rmb_state: got %0d expected S_PIPE", dut.state); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    dma_valid = 1'b0;
    #1;
    chk_cnt++; if (mem_we !== 1'b1) $display("FAIL rmb_post_we: got %b expected 1", mem_we); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL rmb_post_stall: got %b expected 0", stall_o); else pass_cnt++;
    tick();
    pipe_we = 1'b0;
    #1;
    chk_cnt++; if (pipe_rd !== 32'hCAFEF00D) $display("FAIL rmb_post_rd: got %h expected cafef00d", pipe_rd); else pass_cnt++;
    tick();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    test_reset();
    test_pipe_store_load();
    test_dma_rw();
    test_contention();
    test_idle_burst();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline's memory-stage load/store port and a DMA/boot-loader port.
- Sits between the memory stage and the data memory.
- Owns the memory-stage stall: freezes upstream pipeline registers and bubbles M/W whenever the DMA port wins a cycle the pipeline wanted.
- Fixed pipeline priority, with starvation-bounded DMA bursts.

Parameters:
- MAX_WAIT, 8: consecutive denied DMA cycles before the DMA port is forced a grant (1..255).
- BURST_MAX, 4: maximum consecutive DMA beats once granted while the pipeline is requesting (1..255).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_req  in  1  memory stage holds a load or store
- pipe_we  in  1  store when 1
- pipe_addr  in  AW  ALU result address
- pipe_wd  in  DW  store data
- pipe_rd  out  DW  load data, combinational, to the M/W register
- stall_o  out  1  freeze PC, F/D, D/E, E/M; insert bubble (regwrite=0) into M/W
- dma_valid  in  1  DMA request
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wd  in  DW  DMA write data
- dma_ready  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  read data valid (one cycle after an accepted read)
- dma_rdata  out  DW  registered read data
- mem_we  out  1  to data memory
- mem_a  out  AW  to data memory
- mem_wd  out  DW  to data memory
- mem_rd  in  DW  combinational read data from data memory

Behaviour:
- Reset, asynchronous: state=S_PIPE, wait_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
  - Combinational outputs under reset: stall_o=0, dma_ready=0, mem_we=0.
- States:
  - S_PIPE: pipeline owns the memory.
  - S_DMA: DMA owns the memory.
- grant_dma is combinational:
  - In S_PIPE: dma_valid && (!pipe_req || wait_cnt==MAX_WAIT).
  - In S_DMA: dma_valid && (!pipe_req || beat_cnt<BURST_MAX).
- Outputs derived from grant_dma:
  - dma_ready = grant_dma.
  - stall_o = grant_dma && pipe_req.
- Memory mux:
  - When grant_dma: mem_a/mem_wd/mem_we take dma_addr/dma_wd/dma_we.
  - Otherwise: they take pipe_addr/pipe_wd and mem_we = pipe_req && pipe_we.
  - With no requester, mem_we=0 and mem_a=pipe_addr.
- pipe_rd = mem_rd at all times. It is only meaningful when !stall_o.
- Transitions:
  - S_PIPE -> S_DMA on grant_dma.
  - S_DMA -> S_PIPE when !grant_dma.
  - Otherwise remain.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on dma_valid && !grant_dma.
  - Clears on grant_dma or !dma_valid.
- beat_cnt:
  - Cleared on entry to S_DMA, then set to 1 on the first beat.
  - Increments, saturating at BURST_MAX, on each granted beat while pipe_req=1. Beats with pipe_req=0 do not count.
  - Cleared on return to S_PIPE.
- DMA read return:
  - A granted read (grant_dma && !dma_we) sets dma_rvalid=1 and dma_rdata=mem_rd on the next edge.
  - Otherwise dma_rvalid=0 and dma_rdata holds its value.
- Latency:
  - DMA write completes on the grant edge.
  - DMA read returns 1 cycle after grant.
  - Pipeline access has zero added latency when not stalled.
- The pipeline is never granted while stall_o=1.
- A stalled pipeline access retries automatically, because the E/M register holds.
- Boundary conditions:
  - Simultaneous requests with wait_cnt<MAX_WAIT: pipeline wins; DMA waits.
  - At wait_cnt==MAX_WAIT: DMA wins even though pipe_req=1.
  - BURST_MAX reached with pipe_req=1: the pipeline wins the next cycle, and the DMA restarts its wait count at 0.
  - dma_valid dropped mid-burst: return to S_PIPE with no stall.
  - Reset mid-burst: burst abandoned and dma_rvalid cleared. The DMA master must reissue.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and dma_beats[31:0].
  - stall_cnt counts cycles with stall_o=1; dma_beats counts granted DMA beats.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined: the ports are absent and no counter logic is generated. Arbitration is identical either way.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enum {S_PIPE, S_DMA};
  - default MAX_WAIT and BURST_MAX;
  - the AW/DW defaults matching the data memory.
- One sub-module: dmem_arb_starve_ctr, a saturating counter with clear, instantiated for both wait_cnt and beat_cnt.

Test Plan:
- Pipeline-only store then load: pipe_we=1, pipe_addr=0x10, pipe_wd=0xDEADBEEF, next cycle a load of 0x10 -> mem_we pulse, then pipe_rd=0xDEADBEEF with stall_o=0 throughout.
- DMA-only read: DMA write 0x20=0x12345678, then a DMA read of 0x20 -> dma_ready=1 on both beats, dma_rvalid=1 one cycle after the read with dma_rdata=0x12345678.
- Contention starvation: pipe_req=1 and dma_valid=1 held continuously, MAX_WAIT=8, BURST_MAX=4 -> 8 pipeline cycles, then 4 DMA beats with stall_o=1, then pipeline again; the pattern repeats.
- Idle-pipeline burst: pipe_req=0, 10 DMA beats -> all granted, beat_cnt not advanced, stall_o=0.
- Reset mid-burst: assert rst_n=0 during the 2nd DMA beat -> state=S_PIPE, dma_rvalid=0, stall_o=0 immediately; after release, pipeline access proceeds normally.
- With DMEM_ARB_PERF_EN: repeat the contention scenario for 24 cycles -> stall_cnt=8, dma_beats=8.
